// File: rtl/udlx_mem_arbiter_pkg.sv
// Shared types and default widths for the UDLX memory-port arbiter.
package udlx_mem_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 20;
   localparam int unsigned DEF_DATA_WIDTH = 32;

   typedef enum logic {IDLE, BUSY} state_t;

   typedef enum logic [1:0] {OWN_NONE, OWN_BOOT, OWN_DATA, OWN_INSTR} owner_t;

endpackage

// File: rtl/udlx_mem_arb_select.sv
// Priority pick between boot, data and fetch requesters, plus the fetch
// starvation counter that forces an instruction grant after a run of data grants.
module udlx_mem_arb_select
   import udlx_mem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
)(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   boot_mode,
   input  logic   boot_req,
   input  logic   data_req,
   input  logic   instr_req,
   input  logic   grant_en,
   output owner_t pick
);

   localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_cnt;

   always_comb begin
      pick = OWN_NONE;
      if (boot_mode) begin
         if (boot_req) pick = OWN_BOOT;
      end else if (instr_req && starve_cnt == LIMIT) begin
         pick = OWN_INSTR;
      end else if (data_req) begin
         pick = OWN_DATA;
      end else if (instr_req) begin
         pick = OWN_INSTR;
      end
   end

   // Only grants actually taken in IDLE move the counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (grant_en) begin
         if (pick == OWN_INSTR) begin
            starve_cnt <= '0;
         end else if (pick == OWN_DATA && instr_req && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/udlx_mem_arbiter.sv
// Serialises boot, CPU data and CPU fetch transactions onto the single
// SDRAM controller port, one transaction in flight at a time.
module udlx_mem_arbiter
   import udlx_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int unsigned STARVE_LIMIT = 4
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  boot_mode,
   input  logic                  boot_req,
   input  logic [ADDR_WIDTH-1:0] boot_addr,
   input  logic [DATA_WIDTH-1:0] boot_wdata,
   output logic                  boot_ack,
   input  logic                  instr_rd_en,
   input  logic [ADDR_WIDTH-1:0] instr_addr,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic                  instr_ack,
   input  logic                  data_rd_en,
   input  logic                  data_wr_en,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [DATA_WIDTH-1:0] data_write,
   output logic [DATA_WIDTH-1:0] data_read,
   output logic                  data_ack,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ack,
   output logic                  protocol_err
);

   state_t state;
   owner_t owner;
   owner_t pick;
   logic   grant_en;
   logic   data_req;

   assign data_req = data_rd_en | data_wr_en;
   assign grant_en = (state == IDLE);

   udlx_mem_arb_select #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_sel (
      .clk       (clk),
      .rst_n     (rst_n),
      .boot_mode (boot_mode),
      .boot_req  (boot_req),
      .data_req  (data_req),
      .instr_req (instr_rd_en),
      .grant_en  (grant_en),
      .pick      (pick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         owner        <= OWN_NONE;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         boot_ack     <= 1'b0;
         data_ack     <= 1'b0;
         instr_ack    <= 1'b0;
         data_read    <= '0;
         instruction  <= '0;
         protocol_err <= 1'b0;
      end else begin
         boot_ack  <= 1'b0;
         data_ack  <= 1'b0;
         instr_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (pick != OWN_NONE) begin
                  state   <= BUSY;
                  owner   <= pick;
                  mem_req <= 1'b1;
                  case (pick)
                     OWN_BOOT: begin
                        mem_addr  <= boot_addr;
                        mem_wdata <= boot_wdata;
                        mem_we    <= 1'b1;
                     end
                     OWN_DATA: begin
                        // A simultaneous read+write is issued as a write.
                        mem_addr  <= data_addr;
                        mem_wdata <= data_write;
                        mem_we    <= data_wr_en;
                        if (data_rd_en && data_wr_en) protocol_err <= 1'b1;
                     end
                     default: begin
                        mem_addr <= instr_addr;
                        mem_we   <= 1'b0;
                     end
                  endcase
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  case (owner)
                     OWN_BOOT: boot_ack <= 1'b1;
                     OWN_DATA: begin
                        data_ack <= 1'b1;
                        if (!mem_we) data_read <= mem_rdata;
                     end
                     OWN_INSTR: begin
                        instr_ack   <= 1'b1;
                        instruction <= mem_rdata;
                     end
                     default: ;
                  endcase
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udlx_mem_arbiter.sv
// Directed bench for udlx_mem_arbiter with a transaction-level reference model.
module tb_udlx_mem_arbiter;

   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 20;
   localparam int          LIM = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          boot_mode, boot_req, boot_ack;
   logic [AW-1:0] boot_addr;
   logic [DW-1:0] boot_wdata;
   logic          instr_rd_en, instr_ack;
   logic [AW-1:0] instr_addr;
   logic [DW-1:0] instruction;
   logic          data_rd_en, data_wr_en, data_ack;
   logic [AW-1:0] data_addr;
   logic [DW-1:0] data_write, data_read;
   logic          mem_req, mem_we, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          protocol_err;

   int tests = 0;
   int fails = 0;

   udlx_mem_arbiter #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .STARVE_LIMIT (LIM)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .boot_mode    (boot_mode),
      .boot_req     (boot_req),
      .boot_addr    (boot_addr),
      .boot_wdata   (boot_wdata),
      .boot_ack     (boot_ack),
      .instr_rd_en  (instr_rd_en),
      .instr_addr   (instr_addr),
      .instruction  (instruction),
      .instr_ack    (instr_ack),
      .data_rd_en   (data_rd_en),
      .data_wr_en   (data_wr_en),
      .data_addr    (data_addr),
      .data_write   (data_write),
      .data_read    (data_read),
      .data_ack     (data_ack),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack),
      .protocol_err (protocol_err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Reference model: one in-flight transaction, who: 1 boot, 2 data, 3 fetch.
   bit            f_active = 1'b0;
   int            f_who = 0;
   bit            f_we = 1'b0;
   logic [AW-1:0] f_addr = '0;
   logic [DW-1:0] f_wdata = '0;
   int            m_cnt = 0;
   bit            e_boot_ack = 1'b0, e_data_ack = 1'b0, e_instr_ack = 1'b0, e_perr = 1'b0;
   logic [DW-1:0] e_instruction = '0, e_data_read = '0;
   int            grant_log[$];
   int            instr_ack_cnt = 0;

   function automatic int winner();
      if (boot_mode) return boot_req ? 1 : 0;
      if (instr_rd_en && m_cnt == LIM) return 3;
      if (data_rd_en || data_wr_en) return 2;
      if (instr_rd_en) return 3;
      return 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_active      <= 1'b0;
         f_who         <= 0;
         m_cnt         <= 0;
         e_boot_ack    <= 1'b0;
         e_data_ack    <= 1'b0;
         e_instr_ack   <= 1'b0;
         e_perr        <= 1'b0;
         e_instruction <= '0;
         e_data_read   <= '0;
      end else begin
         e_boot_ack  <= 1'b0;
         e_data_ack  <= 1'b0;
         e_instr_ack <= 1'b0;
         if (f_active) begin
            if (mem_ack) begin
               f_active <= 1'b0;
               if (f_who == 1) e_boot_ack <= 1'b1;
               else if (f_who == 2) begin
                  e_data_ack <= 1'b1;
                  if (!f_we) e_data_read <= mem_rdata;
               end else begin
                  e_instr_ack   <= 1'b1;
                  e_instruction <= mem_rdata;
               end
            end
         end else begin
            case (winner())
               1: begin
                  f_active <= 1'b1; f_who <= 1; f_we <= 1'b1;
                  f_addr <= boot_addr; f_wdata <= boot_wdata;
                  grant_log.push_back(1);
               end
               2: begin
                  f_active <= 1'b1; f_who <= 2; f_we <= data_wr_en;
                  f_addr <= data_addr; f_wdata <= data_write;
                  if (data_rd_en && data_wr_en) e_perr <= 1'b1;
                  if (instr_rd_en && m_cnt < LIM) m_cnt <= m_cnt + 1;
                  grant_log.push_back(2);
               end
               3: begin
                  f_active <= 1'b1; f_who <= 3; f_we <= 1'b0;
                  f_addr <= instr_addr;
                  m_cnt <= 0;
                  grant_log.push_back(3);
               end
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      check("mem_req", 64'(mem_req), 64'(f_active));
      check("boot_ack", 64'(boot_ack), 64'(e_boot_ack));
      check("data_ack", 64'(data_ack), 64'(e_data_ack));
      check("instr_ack", 64'(instr_ack), 64'(e_instr_ack));
      check("protocol_err", 64'(protocol_err), 64'(e_perr));
      check("data_read", 64'(data_read), 64'(e_data_read));
      check("instruction", 64'(instruction), 64'(e_instruction));
      if (f_active) begin
         check("mem_we", 64'(mem_we), 64'(f_we));
         check("mem_addr", 64'(mem_addr), 64'(f_addr));
         if (f_we) check("mem_wdata", 64'(mem_wdata), 64'(f_wdata));
      end
      if (instr_ack) instr_ack_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Controller stand-in: ack arrives `lat` edges after mem_req was first seen high.
   task automatic serve(input int lat, input logic [DW-1:0] rd);
      int n = 0;
      while (mem_req !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      if (mem_req !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL serve_timeout: mem_req=%b, want 1", mem_req);
         return;
      end
      for (int i = 1; i < lat; i++) step();
      mem_ack   = 1'b1;
      mem_rdata = rd;
      step();
      mem_ack = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_log[$];
      int base;

      rst_n = 1'b0; boot_mode = 1'b0; boot_req = 1'b0; boot_addr = '0; boot_wdata = '0;
      instr_rd_en = 1'b0; instr_addr = '0; data_rd_en = 1'b0; data_wr_en = 1'b0;
      data_addr = '0; data_write = '0; mem_rdata = '0; mem_ack = 1'b0;
      step(); step();
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_acks", 64'({boot_ack, data_ack, instr_ack}), 64'd0);
      check("rst_perr", 64'(protocol_err), 64'd0);
      rst_n = 1'b1;
      step();

      // single load
      data_addr = 20'h00010; data_rd_en = 1'b1;
      step();
      check("t1_mem_req", 64'(mem_req), 64'd1);
      check("t1_mem_we", 64'(mem_we), 64'd0);
      check("t1_mem_addr", 64'(mem_addr), 64'h10);
      serve(2, 32'hDEADBEEF);
      data_rd_en = 1'b0;
      check("t1_data_ack", 64'(data_ack), 64'd1);
      check("t1_data_read", 64'(data_read), 64'hDEADBEEF);
      check("t1_req_low", 64'(mem_req), 64'd0);
      check("t1_perr", 64'(protocol_err), 64'd0);
      step();
      check("t1_ack_once", 64'(data_ack), 64'd0);

      // starvation
      grant_log.delete();
      instr_addr = 20'h00200; data_addr = 20'h00100;
      data_rd_en = 1'b1; instr_rd_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         serve(1, 32'h1000_0000 + 32'(k));
         if (k == 4) begin
            data_rd_en = 1'b0; instr_rd_en = 1'b0;
         end
      end
      check("t2_instr_ack", 64'(instr_ack), 64'd1);
      check("t2_instruction", 64'(instruction), 64'h10000004);
      check("t2_starve_cnt", 64'(u_dut.u_sel.starve_cnt), 64'd0);
      exp_log = '{2, 2, 2, 2, 3};
      check("t2_grant_count", 64'(grant_log.size()), 64'd5);
      for (int k = 0; k < 5 && k < grant_log.size(); k++)
         check("t2_grant_order", 64'(grant_log[k]), 64'(exp_log[k]));
      step();

      // boot priority, then data ahead of fetch
      grant_log.delete();
      boot_mode = 1'b1; boot_req = 1'b1; boot_addr = 20'h80004; boot_wdata = 32'hB0070001;
      instr_rd_en = 1'b1; data_wr_en = 1'b1; data_write = 32'h5555AAAA; data_addr = 20'h00300;
      step();
      check("t3_mem_we", 64'(mem_we), 64'd1);
      check("t3_mem_addr", 64'(mem_addr), 64'h80004);
      check("t3_mem_wdata", 64'(mem_wdata), 64'hB0070001);
      serve(1, 32'h0);
      check("t3_boot_ack", 64'(boot_ack), 64'd1);
      boot_addr = 20'h80008; boot_wdata = 32'hB0070002;
      serve(1, 32'h0);
      boot_req = 1'b0; boot_mode = 1'b0;
      serve(1, 32'h0);
      data_wr_en = 1'b0;
      check("t3_data_ack", 64'(data_ack), 64'd1);
      serve(1, 32'h00001234);
      instr_rd_en = 1'b0;
      check("t3_instruction", 64'(instruction), 64'h1234);
      exp_log = '{1, 1, 2, 3};
      check("t3_grant_count", 64'(grant_log.size()), 64'd4);
      for (int k = 0; k < 4 && k < grant_log.size(); k++)
         check("t3_grant_order", 64'(grant_log[k]), 64'(exp_log[k]));
      step();

      // simultaneous read and write
      data_rd_en = 1'b1; data_wr_en = 1'b1; data_write = 32'h12345678; data_addr = 20'h00400;
      step();
      check("t4_mem_we", 64'(mem_we), 64'd1);
      check("t4_mem_wdata", 64'(mem_wdata), 64'h12345678);
      check("t4_perr_set", 64'(protocol_err), 64'd1);
      serve(1, 32'hFFFFFFFF);
      data_rd_en = 1'b0; data_wr_en = 1'b0;
      check("t4_read_kept", 64'(data_read), 64'h10000003);
      repeat (3) step();
      check("t4_perr_sticky", 64'(protocol_err), 64'd1);

      // reset mid-transaction
      instr_rd_en = 1'b1; instr_addr = 20'h00500;
      step();
      check("t5_mem_req", 64'(mem_req), 64'd1);
      step(); step(); step();
      rst_n = 1'b0;
      #1;
      check("t5_req_drop", 64'(mem_req), 64'd0);
      check("t5_no_ack", 64'({boot_ack, data_ack, instr_ack}), 64'd0);
      check("t5_perr_clr", 64'(protocol_err), 64'd0);
      instr_rd_en = 1'b0;
      step(); step();
      rst_n = 1'b1;
      base = instr_ack_cnt;
      repeat (3) step();
      check("t5_no_late_ack", 64'(instr_ack_cnt - base), 64'd0);
      data_rd_en = 1'b1; data_addr = 20'h80010;
      step();
      check("t5_mem_addr", 64'(mem_addr), 64'h80010);
      serve(3, 32'hCAFEF00D);
      data_rd_en = 1'b0;
      check("t5_data_ack", 64'(data_ack), 64'd1);
      check("t5_data_read", 64'(data_read), 64'hCAFEF00D);
      step();

      // withdrawn fetch, then an unsolicited controller ack
      base = instr_ack_cnt;
      instr_rd_en = 1'b1; instr_addr = 20'h00600;
      step();
      check("t6_mem_req", 64'(mem_req), 64'd1);
      instr_rd_en = 1'b0;
      serve(2, 32'h0BADC0DE);
      check("t6_instr_ack", 64'(instr_ack), 64'd1);
      check("t6_instruction", 64'(instruction), 64'h0BADC0DE);
      step(); step();
      mem_ack = 1'b1; mem_rdata = 32'h77777777;
      step();
      mem_ack = 1'b0;
      step(); step();
      check("t6_ack_once", 64'(instr_ack_cnt - base), 64'd1);
      check("t6_idle", 64'(mem_req), 64'd0);
      check("t6_instr_kept", 64'(instruction), 64'h0BADC0DE);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
